// File: rtl/writeback_queue_if.sv
// Handshake and register-file write bundle for writeback_queue.
// Lookup signals exist only when WBQ_LOOKUP_EN is defined.
interface writeback_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_dest;
  logic [WIDTH-1:0] in_data;
  logic             wb_stall;
  logic             flush;
  logic             write_enable;
  logic [3:0]       Destination_select;
  logic [WIDTH-1:0] DATA;
  logic             pc_write;
  logic [CW-1:0]    count;
`ifdef WBQ_LOOKUP_EN
  logic [3:0]       lookup_select;
  logic             lookup_hit;
  logic [WIDTH-1:0] lookup_data;
`endif

  modport slave (
    input  in_valid, in_dest, in_data, wb_stall, flush,
    output in_ready, write_enable, Destination_select, DATA, pc_write, count
`ifdef WBQ_LOOKUP_EN
    , input lookup_select
    , output lookup_hit, lookup_data
`endif
  );

  modport master (
    output in_valid, in_dest, in_data, wb_stall, flush,
    input  in_ready, write_enable, Destination_select, DATA, pc_write, count
`ifdef WBQ_LOOKUP_EN
    , output lookup_select
    , input lookup_hit, lookup_data
`endif
  );
endinterface

// File: rtl/writeback_queue.sv
// Circular write-back queue between execute and the register file; R15 writes go to the PC path.
// Optional forwarding lookup of queued data is enabled by defining WBQ_LOOKUP_EN.
module writeback_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [3:0]       destMem_q [DEPTH];
  logic [WIDTH-1:0] dataMem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  logic       notEmpty;
  logic       push;
  logic       pop;
  logic [3:0] headDest;

  assign notEmpty = (count_q != '0);
  assign headDest = destMem_q[rdPtr_q];
  assign push     = bus.in_valid && bus.in_ready && !bus.flush && !reset;
  assign pop      = notEmpty && !bus.wb_stall && !bus.flush && !reset;

  assign bus.in_ready           = (count_q < DepthC);
  assign bus.count              = count_q;
  assign bus.Destination_select = notEmpty ? headDest : 4'd0;
  assign bus.DATA               = notEmpty ? dataMem_q[rdPtr_q] : '0;
  assign bus.write_enable       = pop && (headDest != 4'd15);
  assign bus.pc_write           = pop && (headDest == 4'd15);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy is defined solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      destMem_q[wrPtr_q] <= bus.in_dest;
      dataMem_q[wrPtr_q] <= bus.in_data;
    end
  end

`ifdef WBQ_LOOKUP_EN
  logic             lookupHit;
  logic [WIDTH-1:0] lookupData;
  logic [PW-1:0]    lookupIdx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    lookupIdx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookupIdx = rdPtr_q + PW'(i);
      if ((CW'(i) < count_q) && (bus.lookup_select != 4'd15) &&
          (destMem_q[lookupIdx] == bus.lookup_select)) begin
        lookupHit  = 1'b1;
        lookupData = dataMem_q[lookupIdx];
      end
    end
  end

  assign bus.lookup_hit  = lookupHit;
  assign bus.lookup_data = lookupData;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue with a small in-order scoreboard.
// Lookup checks run only when WBQ_LOOKUP_EN is defined.
module tb_writeback_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   seqNo;

  logic [3:0]  sbDest [$];
  logic [31:0] sbData [$];

  writeback_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  writeback_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic [31:0] data,
                               input logic stall, input logic fl);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_dest  = d;
    bus.in_data  = data;
    bus.wb_stall = stall;
    bus.flush    = fl;
    #1;
  endtask

  task automatic doReset(input logic v);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = v;
    bus.in_dest  = 4'd2;
    bus.in_data  = 32'hBAD0_0001;
    bus.wb_stall = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_we", bus.write_enable, 0);
    checkOutput("rst_pc_write", bus.pc_write, 0);
    checkOutput("rst_dest", bus.Destination_select, 0);
    checkOutput("rst_data", bus.DATA, 0);
  endtask

  task automatic scoreboardStep(input logic stall);
    logic [3:0]  d;
    logic [31:0] v;
    int          sizeBefore;
    d = 4'(seqNo % 15);
    v = 32'h0000_1000 + 32'(seqNo);
    seqNo++;
    applyStimulus(1'b1, d, v, stall, 1'b0);
    sizeBefore = sbData.size();
    checkOutput("sb_count", bus.count, 64'(sizeBefore));
    checkOutput("sb_in_ready", bus.in_ready, (sizeBefore < DEPTH) ? 1 : 0);
    if (sizeBefore > 0 && !stall) begin
      checkOutput("sb_we", bus.write_enable, 1);
      checkOutput("sb_dest", bus.Destination_select, sbDest[0]);
      checkOutput("sb_data", bus.DATA, sbData[0]);
      void'(sbDest.pop_front());
      void'(sbData.pop_front());
    end else begin
      checkOutput("sb_we_idle", bus.write_enable, 0);
    end
    if (sizeBefore < DEPTH) begin
      sbDest.push_back(d);
      sbData.push_back(v);
    end
  endtask

  initial begin
    logic [11:0] stallPat;
    total        = 0;
    bad          = 0;
    seqNo        = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_dest  = 4'd0;
    bus.in_data  = '0;
    bus.wb_stall = 1'b0;
    bus.flush    = 1'b0;
`ifdef WBQ_LOOKUP_EN
    bus.lookup_select = 4'd0;
`endif
    doReset(1'b0);

    // Single write passes through with one cycle of latency.
    applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkOutput("single_no_passthru", bus.write_enable, 0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("single_we", bus.write_enable, 1);
    checkOutput("single_dest", bus.Destination_select, 3);
    checkOutput("single_data", bus.DATA, 32'hDEAD_BEEF);
    checkOutput("single_pc_write", bus.pc_write, 0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("single_count_back", bus.count, 0);
    checkOutput("single_we_off", bus.write_enable, 0);

    // Fill under stall, reject a fifth push, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i), 32'h0000_00A0 + 32'(i), 1'b1, 1'b0);
      checkOutput("fill_stall_we", bus.write_enable, 0);
    end
    applyStimulus(1'b1, 4'd5, 32'h0000_00A5, 1'b1, 1'b0);
    checkOutput("full_count", bus.count, 4);
    checkOutput("full_in_ready", bus.in_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
      checkOutput("drain_we", bus.write_enable, 1);
      checkOutput("drain_dest", bus.Destination_select, 64'(i));
      checkOutput("drain_data", bus.DATA, 64'(32'h0000_00A0 + 32'(i)));
      checkOutput("drain_count", bus.count, 64'(5 - i));
    end
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("drain_empty", bus.count, 0);
    checkOutput("drain_no_fifth", bus.write_enable, 0);

    // R15 goes to the PC path.
    applyStimulus(1'b1, 4'd15, 32'h0000_0100, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("r15_pc_write", bus.pc_write, 1);
    checkOutput("r15_we", bus.write_enable, 0);
    checkOutput("r15_data", bus.DATA, 32'h0000_0100);
    checkOutput("r15_dest", bus.Destination_select, 15);

    // Flush discards queued entries and drops a concurrent push.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'(7 + i), 32'h0000_0700 + 32'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 4'd10, 32'h0000_0710, 1'b0, 1'b1);
    checkOutput("flush_count_before", bus.count, 3);
    checkOutput("flush_we", bus.write_enable, 0);
    checkOutput("flush_pc_write", bus.pc_write, 0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_count", bus.count, 0);
    checkOutput("flush_we_after", bus.write_enable, 0);
    checkOutput("flush_dest_after", bus.Destination_select, 0);

`ifdef WBQ_LOOKUP_EN
    applyStimulus(1'b1, 4'd5, 32'h0000_0011, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd5, 32'h0000_0022, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    bus.lookup_select = 4'd5;
    #1;
    checkOutput("lookup5_hit", bus.lookup_hit, 1);
    checkOutput("lookup5_data", bus.lookup_data, 32'h0000_0022);
    bus.lookup_select = 4'd6;
    #1;
    checkOutput("lookup6_hit", bus.lookup_hit, 0);
    bus.lookup_select = 4'd15;
    #1;
    checkOutput("lookup15_hit", bus.lookup_hit, 0);
    checkOutput("lookup15_data", bus.lookup_data, 0);
    bus.lookup_select = 4'd0;
    doReset(1'b0);
`endif

    // Mixed push/pop with stall toggling wraps the pointers; reset lands mid-drain.
    stallPat = 12'b0000_0010_1111;
    for (int i = 0; i < 8; i++) begin
      scoreboardStep(stallPat[i]);
    end
    doReset(1'b1);
    sbDest.delete();
    sbData.delete();
    for (int i = 8; i < 12; i++) begin
      scoreboardStep(stallPat[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
